// File: rtl/jtpopeye_vram_arb.sv
// Purpose: arbitrates one synchronous background RAM between the video fetcher and the CPU.
// Latency: grant in the request clk; video data 2 clk later (vid_ok); CPU access IDLE->RD/WR->DONE.
// Backpressure: CPU held via combinational wait_n; video waits while vid_req is held; starvation guard.
module jtpopeye_vram_arb #(
    parameter int STARVE = 8,
    parameter int AW     = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          HB,
    input  logic          VB,
    input  logic          CSBW_n,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_ok,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VID    = 3'd1,
        CPU_RD = 3'd2,
        CPU_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [3:0]    starve_cnt;
    logic          done;       // CPU access finished, cleared when CSBW_n releases
    logic          wait_rel;   // done delayed one clk: releases wait_n
    logic [AW-1:0] addr_r;     // address latched at grant, drives RAM outside IDLE
    logic [7:0]    din_r;      // write data latched at grant

    logic          cpu_pend;
    logic          vid_pend;
    logic          cpu_pri;
    logic          cpu_win;
    logic          vid_win;

    // A CPU access in flight is not a new request; reset masks requests so the
    // RAM address reads zero while rst_n is low.
    assign cpu_pend = rst_n & ~CSBW_n & ~done & (state != CPU_RD) & (state != CPU_WR);
    assign vid_pend = rst_n & vid_req;

    // CPU takes precedence during blanking or once it has waited too long.
    assign cpu_pri  = HB | VB | (32'(starve_cnt) >= STARVE);

    // Next-state and grant decision; arbitration only happens in IDLE.
    always_comb begin
        state_nx = state;
        cpu_win  = 1'b0;
        vid_win  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_pend && (cpu_pri || !vid_pend)) begin
                    cpu_win  = 1'b1;
                    state_nx = cpu_we ? CPU_WR : CPU_RD;
                end else if (vid_pend) begin
                    vid_win  = 1'b1;
                    state_nx = VID;
                end
            end
            VID:    state_nx = IDLE;
            CPU_RD: state_nx = DONE;
            CPU_WR: state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM address: the winner's address on the grant clk so data is ready in the
    // following state, otherwise the address latched at grant.
    always_comb begin
        ram_addr = addr_r;
        if (cpu_win) begin
            ram_addr = cpu_addr;
        end else if (vid_win) begin
            ram_addr = vid_addr;
        end
    end

    assign ram_we  = (state == CPU_WR);
    assign ram_din = din_r;

    // CPU is stalled from the moment it selects the RAM until one clk after done.
    assign wait_n  = CSBW_n | wait_rel;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the granted address and write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            din_r  <= 8'd0;
        end else if (cpu_win) begin
            addr_r <= cpu_addr;
            din_r  <= cpu_din;
        end else if (vid_win) begin
            addr_r <= vid_addr;
        end
    end

    // Starvation counter: counts pixel enables the CPU spends waiting, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (cpu_win) begin
            starve_cnt <= 4'd0;
        end else if (pxl_cen && cpu_pend && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Done flag and its delayed copy; releasing CSBW_n always wins so an aborted
    // access leaves nothing behind that could block the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            wait_rel <= 1'b0;
        end else if (CSBW_n) begin
            done     <= 1'b0;
            wait_rel <= 1'b0;
        end else begin
            if ((state == CPU_RD) || (state == CPU_WR)) begin
                done <= 1'b1;
            end
            wait_rel <= done;
        end
    end

    // CPU read data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_dout <= 8'd0;
        end else if (state == CPU_RD) begin
            cpu_dout <= ram_dout;
        end
    end

    // Video read data capture with a one-clk valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_dout <= 8'd0;
            vid_ok   <= 1'b0;
        end else begin
            vid_ok <= (state == VID);
            if (state == VID) begin
                vid_dout <= ram_dout;
            end
        end
    end

endmodule
